// File: rtl/chunked_mult_pkg.sv
// Shared types and sizing helpers for the chunked sequential multiplier.
package chunked_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of CHUNK-bit slices per operand.
  function automatic int calc_k(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Slice index width; a single-slice operand still needs a 1-bit counter.
  function automatic int calc_idx_w(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/chunk_aligner.sv
// Places a 2*CHUNK partial product at bit position CHUNK*(i+j) of the 2*WIDTH sum.
module chunk_aligner #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4,
  parameter int SH_W  = 2
) (
  input  logic [2*CHUNK-1:0] pp_i,
  input  logic [SH_W-1:0]    shift_idx_i,
  output logic [2*WIDTH-1:0] aligned_o
);

  logic [2*WIDTH-1:0] pp_ext;

  assign pp_ext    = (2*WIDTH)'(pp_i);
  assign aligned_o = pp_ext << (CHUNK * shift_idx_i);

endmodule

// File: rtl/chunked_seq_multiplier.sv
// Sequential unsigned multiplier: one CHUNKxCHUNK partial product per RUN cycle.
// Optional macro ZERO_SKIP_EN: a zero operand bypasses RUN and finishes with product 0.
module chunked_seq_multiplier
  import chunked_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output state_t             dbg_state_o
);

  localparam int K     = calc_k(WIDTH, CHUNK);
  localparam int IDX_W = calc_idx_w(K);
  localparam int SH_W  = IDX_W + 1;
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(K - 1);

  // Handshake: start is sampled only in IDLE; busy covers RUN and DONE;
  // done is a one-cycle pulse in DONE while product already holds the result.
  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [IDX_W-1:0]     i_q, i_d, j_q, j_d;

  logic [CHUNK-1:0]     a_sl, b_sl;
  logic [2*CHUNK-1:0]   pp;
  logic [SH_W-1:0]      shift_idx;
  logic [2*WIDTH-1:0]   aligned;
  logic [2*WIDTH-1:0]   sum;
  logic                 last_step;

  assign a_sl      = CHUNK'(a_q >> (CHUNK * i_q));
  assign b_sl      = CHUNK'(b_q >> (CHUNK * j_q));
  assign pp        = (2*CHUNK)'(a_sl) * (2*CHUNK)'(b_sl);
  assign shift_idx = {1'b0, i_q} + {1'b0, j_q};
  assign sum       = acc_q + aligned;
  assign last_step = (i_q == K_LAST) && (j_q == K_LAST);

  chunk_aligner #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK),
    .SH_W  (SH_W)
  ) u_aligner (
    .pp_i        (pp),
    .shift_idx_i (shift_idx),
    .aligned_o   (aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      i_q       <= '0;
      j_q       <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      i_q       <= i_d;
      j_q       <= j_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    product_d = product_q;
    i_d       = i_q;
    j_d       = j_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          acc_d = '0;
          i_d   = '0;
          j_d   = '0;
`ifdef ZERO_SKIP_EN
          if ((a == '0) || (b == '0)) begin
            product_d = '0;
            state_d   = DONE;
          end else begin
            state_d = RUN;
          end
`else
          state_d = RUN;
`endif
        end
      end
      RUN: begin
        acc_d = sum;
        if (j_q == K_LAST) begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
        if (last_step) begin
          product_d = sum;
          i_d       = '0;
          j_d       = '0;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign product     = product_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_chunked_seq_multiplier.sv
// Bench for chunked_seq_multiplier: three instances (K=2, K=4, K=1) against a cycle-level model.
module tb_chunked_seq_multiplier;
  import chunked_mult_pkg::*;

`ifdef ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam int K_OF [3] = '{2, 4, 1};
  localparam int W_OF [3] = '{8, 16, 4};

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_v [3];
  logic [15:0] a_v [3];
  logic [15:0] b_v [3];
  logic        busy_w [3];
  logic        done_w [3];
  state_t      st_w [3];
  logic [15:0] p0;
  logic [31:0] p1;
  logic [7:0]  p2;

  int tests = 0;
  int fails = 0;

  chunked_seq_multiplier #(.WIDTH(8), .CHUNK(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0][7:0]), .b(b_v[0][7:0]),
    .busy(busy_w[0]), .done(done_w[0]), .product(p0), .dbg_state_o(st_w[0]));

  chunked_seq_multiplier #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
    .busy(busy_w[1]), .done(done_w[1]), .product(p1), .dbg_state_o(st_w[1]));

  chunked_seq_multiplier #(.WIDTH(4), .CHUNK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2][3:0]), .b(b_v[2][3:0]),
    .busy(busy_w[2]), .done(done_w[2]), .product(p2), .dbg_state_o(st_w[2]));

  function automatic logic [31:0] dut_prod(input int n);
    case (n)
      0:       return {16'h0, p0};
      1:       return p1;
      default: return {24'h0, p2};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: accepted start -> product a*b appears after K*K cycles of work
  bit          m_busy [3];
  bit          m_done [3];
  logic [31:0] m_prod [3];
  logic [31:0] m_pend [3];
  int          m_cnt  [3];

  initial begin
    for (int n = 0; n < 3; n++) begin
      m_busy[n] = 0; m_done[n] = 0; m_prod[n] = 0; m_pend[n] = 0; m_cnt[n] = 0;
      start_v[n] = 0; a_v[n] = 0; b_v[n] = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int n = 0; n < 3; n++) begin
      if (!rst_n) begin
        m_busy[n] = 0; m_done[n] = 0; m_prod[n] = 0; m_cnt[n] = 0;
      end else if (m_done[n]) begin
        m_done[n] = 0;
        m_busy[n] = 0;
      end else if (m_busy[n]) begin
        m_cnt[n]--;
        if (m_cnt[n] == 0) begin
          m_prod[n] = m_pend[n];
          m_done[n] = 1;
        end
      end else if (start_v[n]) begin
        m_pend[n] = 32'(a_v[n]) * 32'(b_v[n]);
        m_busy[n] = 1;
        if (SKIP && (a_v[n] == 0 || b_v[n] == 0)) begin
          m_prod[n] = 0;
          m_done[n] = 1;
        end else begin
          m_cnt[n] = K_OF[n] * K_OF[n];
        end
      end
    end
  end

  // compare process: every cycle, every instance
  always @(negedge clk) begin
    for (int n = 0; n < 3; n++) begin
      check($sformatf("busy[%0d]", n), 32'(busy_w[n]), 32'(m_busy[n]));
      check($sformatf("done[%0d]", n), 32'(done_w[n]), 32'(m_done[n]));
      check($sformatf("product[%0d]", n), dut_prod(n), m_prod[n]);
    end
  end

  // driver: caller sits at a negedge; start goes high at the following negedge
  task automatic run_op(input int n, input logic [15:0] a, input logic [15:0] b,
                        input bit hold, input logic [31:0] exp_p, input int exp_cyc,
                        input string name);
    int cnt;
    @(negedge clk);
    start_v[n] = 1; a_v[n] = a; b_v[n] = b;
    @(negedge clk);
    cnt = 0;
    if (hold) begin
      a_v[n] = 16'h1; b_v[n] = 16'h1;
    end else begin
      start_v[n] = 0;
    end
    while (!done_w[n] && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    start_v[n] = 0;
    if (cnt >= 200) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: no done within %0d cycles", name, cnt);
    end else begin
      check({name, " latency"}, 32'(cnt), 32'(exp_cyc));
      check({name, " product"}, dut_prod(n), exp_p);
      check({name, " model"}, m_prod[n], exp_p);
    end
  endtask

  initial begin
    int dcount;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy_w[0]), 32'd0);
    check("reset done", 32'(done_w[0]), 32'd0);
    check("reset product", dut_prod(0), 32'd0);
    check("reset state", 32'(st_w[0]), 32'(IDLE));
    #2 rst_n = 1'b1;
    @(negedge clk);

    run_op(0, 16'h00FF, 16'h00FF, 0, 32'hFE01, 4, "ff_x_ff");
    run_op(0, 16'h0012, 16'h0034, 0, 32'h03A8, 4, "12_x_34");
    run_op(0, 16'h0034, 16'h0012, 0, 32'h03A8, 4, "34_x_12_b2b");

    run_op(0, 16'h0080, 16'h0002, 1, 32'h0100, 4, "hold_start");
    dcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_w[0]) dcount++;
    end
    check("no extra done", 32'(dcount), 32'd0);

    // reset during the second RUN cycle
    @(negedge clk);
    start_v[0] = 1; a_v[0] = 16'h0055; b_v[0] = 16'h0055;
    @(negedge clk);
    start_v[0] = 0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy_w[0]), 32'd0);
    check("midrst done", 32'(done_w[0]), 32'd0);
    check("midrst product", dut_prod(0), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_op(0, 16'h000F, 16'h000F, 0, 32'h00E1, 4, "after_reset");

    run_op(0, 16'h0000, 16'h00AB, 0, 32'h0000, SKIP ? 0 : 4, "zero_a");
    run_op(0, 16'h00AB, 16'h0000, 0, 32'h0000, SKIP ? 0 : 4, "zero_b");

    run_op(1, 16'hFFFF, 16'h1234, 0, 32'h1233EDCC, 16, "w16_ffff_x_1234");
    run_op(1, 16'h00FF, 16'hFF00, 0, 32'h00FE0100, 16, "w16_00ff_x_ff00");

    run_op(2, 16'h000F, 16'h000D, 0, 32'h00C3, 1, "k1_f_x_d");
    run_op(2, 16'h000F, 16'h000F, 0, 32'h00E1, 1, "k1_f_x_f");

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
